// File: rtl/voice_allocator.sv
// voice_allocator: debounces touch keys and assigns held keys to a small pool of voices.
// Optional feature macro VOICE_STEAL_EN: a press with no free voice steals the oldest voice.
module voice_allocator #(
  parameter int NUM_KEYS        = 12,
  parameter int NUM_VOICES      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int KW = $clog2(NUM_KEYS),
  localparam int CW = $clog2(NUM_VOICES + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_KEYS-1:0]      touch_status_in,
  output logic [NUM_VOICES-1:0]    voice_gate_out,
  output logic [NUM_VOICES-1:0]    voice_trigger_out,
  output logic [NUM_VOICES*KW-1:0] voice_note_out,
  output logic [CW-1:0]            active_count_out
);
  localparam int         VW      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [7:0] DB_LIM  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] AGE_MAX = 8'hFF;

  logic [7:0]            cnt_q [NUM_KEYS];
  logic [7:0]            cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]   stable_q, stable_d, stable_prev_q, stable_prev_d;
  logic [NUM_KEYS-1:0]   press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
  logic [KW-1:0]         note_q [NUM_VOICES];
  logic [KW-1:0]         note_d [NUM_VOICES];
  logic [7:0]            age_q [NUM_VOICES];
  logic [7:0]            age_d [NUM_VOICES];
  logic [CW-1:0]         count_q, count_d;

  logic                  rel_found_s, press_found_s, free_found_s, match_found_s;
  logic                  rel_act_s, alloc_s;
  logic [KW-1:0]         rel_key_s, press_key_s;
  logic [VW-1:0]         free_v_s, match_v_s, alloc_v_s;
  logic [NUM_KEYS-1:0]   press_cand_s, rel_clr_s, press_clr_s;

  // Per-key debounce: a key must disagree with its stable level for DEBOUNCE_CYCLES samples.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      stable_d[k] = stable_q[k];
      cnt_d[k]    = 8'd0;
      if (touch_status_in[k] == stable_q[k]) begin
        cnt_d[k] = 8'd0;
      end else if ((cnt_q[k] + 8'd1) == DB_LIM) begin
        stable_d[k] = ~stable_q[k];
        cnt_d[k]    = 8'd0;
      end else begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
    stable_prev_d = stable_q;
  end

  // A key whose release is also pending never competes for a voice.
  assign press_cand_s = press_pend_q & ~rel_pend_q;

  // Lowest-index pending release and press; scanning downward lets the lowest index win.
  always_comb begin
    rel_found_s   = 1'b0;
    rel_key_s     = '0;
    press_found_s = 1'b0;
    press_key_s   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      rel_key_s     = rel_pend_q[k] ? KW'(k) : rel_key_s;
      rel_found_s   = rel_found_s | rel_pend_q[k];
      press_key_s   = press_cand_s[k] ? KW'(k) : press_key_s;
      press_found_s = press_found_s | press_cand_s[k];
    end
  end

  // Voice lookup uses the current gates, so a voice freed this cycle is not yet free.
  always_comb begin
    free_found_s  = 1'b0;
    free_v_s      = '0;
    match_found_s = 1'b0;
    match_v_s     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      free_v_s      = !gate_q[v] ? VW'(v) : free_v_s;
      free_found_s  = free_found_s | !gate_q[v];
      match_v_s     = (gate_q[v] && (note_q[v] == rel_key_s)) ? VW'(v) : match_v_s;
      match_found_s = match_found_s | (gate_q[v] && (note_q[v] == rel_key_s));
    end
  end

  assign rel_act_s = rel_found_s & ~press_pend_q[rel_key_s];

`ifdef VOICE_STEAL_EN
  logic [VW-1:0] old_v_s;

  // Oldest voice, ties resolved toward the lowest index.
  always_comb begin
    old_v_s = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      old_v_s = (age_q[v] > age_q[old_v_s]) ? VW'(v) : old_v_s;
    end
  end

  assign alloc_s   = press_found_s;
  assign alloc_v_s = free_found_s ? free_v_s : old_v_s;
`else
  assign alloc_s   = press_found_s & free_found_s;
  assign alloc_v_s = free_v_s;
`endif

  assign rel_clr_s   = rel_found_s ? (NUM_KEYS'(1) << rel_key_s) : '0;
  assign press_clr_s = rel_clr_s | (alloc_s ? (NUM_KEYS'(1) << press_key_s) : '0);

  // Voice table update; an allocation overrides a release landing on the same voice.
  always_comb begin
    count_d      = '0;
    press_pend_d = (press_pend_q & ~press_clr_s) | (stable_q & ~stable_prev_q);
    rel_pend_d   = (rel_pend_q & ~rel_clr_s) | (~stable_q & stable_prev_q);
    for (int v = 0; v < NUM_VOICES; v++) begin
      logic alloc_hit;
      logic rel_hit;
      alloc_hit = alloc_s & (alloc_v_s == VW'(v));
      rel_hit   = rel_act_s & match_found_s & (match_v_s == VW'(v));
      note_d[v] = alloc_hit ? press_key_s : note_q[v];
      trig_d[v] = alloc_hit;
      gate_d[v] = alloc_hit | (gate_q[v] & ~rel_hit);
      if (alloc_hit) begin
        age_d[v] = 8'd0;
      end else if (alloc_s && (age_q[v] != AGE_MAX)) begin
        age_d[v] = age_q[v] + 8'd1;
      end else begin
        age_d[v] = age_q[v];
      end
      count_d = count_d + CW'(gate_d[v]);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= 8'd0;
      end
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_pend_q  <= '0;
      rel_pend_q    <= '0;
      gate_q        <= '0;
      trig_q        <= '0;
      count_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      press_pend_q  <= press_pend_d;
      rel_pend_q    <= rel_pend_d;
      gate_q        <= gate_d;
      trig_q        <= trig_d;
      count_q       <= count_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= note_d[v];
        age_q[v]  <= age_d[v];
      end
    end
  end

  // Pack per-voice notes onto the flat output bus.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note_out[v*KW +: KW] = note_q[v];
    end
  end

  assign voice_gate_out    = gate_q;
  assign voice_trigger_out = trig_q;
  assign active_count_out  = count_q;

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12: number of touch inputs.
REQ-002 SHALL have parameter NUM_VOICES, default 4: number of output voices.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable cycles needed to accept a key change; range 1..255.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port touch_status_in  input  NUM_KEYS  raw per-key touch level, 1 = touched.
REQ-007 SHALL have port voice_gate_out  output  NUM_VOICES  per-voice gate, high while the voice holds a key.
REQ-008 SHALL have port voice_trigger_out  output  NUM_VOICES  one-cycle pulse on each voice (re)allocation.
REQ-009 SHALL have port voice_note_out  output  NUM_VOICES*KW  per-voice key index, voice v at bits [v*KW +: KW], KW = $clog2(NUM_KEYS).
REQ-010 SHALL have port active_count_out  output  $clog2(NUM_VOICES+1)  number of voices with gate high.

Function
REQ-011 SHALL debounce each key independently: counter resets when raw equals stable state, increments otherwise, and stable state flips when counter reaches DEBOUNCE_CYCLES, counter then clearing.
REQ-012 SHALL set a per-key pending-press flag on a stable 0->1 flip and a pending-release flag on a stable 1->0 flip, one cycle after the flip.
REQ-013 SHALL service per cycle at most one release (lowest pending key index) and at most one press (lowest pending key index).
REQ-014 Release: voice with gate high and note equal to key SHALL drop gate next cycle; note retained; flag cleared; no matching voice -> flag cleared, no effect.
REQ-015 Release of a key whose press is still pending SHALL clear both flags with no voice action.
REQ-016 Press: lowest-index voice with gate low SHALL be allocated: gate 1, note = key, trigger 1 for exactly one cycle, press flag cleared.
REQ-017 Voice freed by a release SHALL NOT be eligible for a press in the same cycle; it becomes eligible next cycle.
REQ-018 Each voice SHALL hold an age counter: cleared on allocation, incremented each allocation event of any other voice, saturating at 2^8-1.
REQ-019 No free voice: behaviour per REQ-024/REQ-025.
REQ-020 With no competing events, gate and trigger SHALL rise exactly DEBOUNCE_CYCLES+2 rising edges after touch_status_in changes and stays stable.
REQ-021 active_count_out SHALL equal popcount of voice_gate_out, registered with it (same cycle).

Reset
REQ-022 While rst_in high, SHALL immediately force: voice_gate_out=0, voice_trigger_out=0, voice_note_out=0, active_count_out=0, all debounce counters/stable states/pending flags/ages = 0.
REQ-023 Reset asserted mid-operation SHALL discard all pending events; keys held through reset release SHALL be re-detected as new presses after DEBOUNCE_CYCLES.

Configuration
REQ-024 With macro VOICE_STEAL_EN defined, a press with no free voice SHALL steal the voice with highest age (ties: lowest index): gate stays 1, note = new key, trigger pulses one cycle, age cleared; release of the stolen key later finds no voice and is ignored.
REQ-025 Without VOICE_STEAL_EN, a press with no free voice SHALL remain pending until a voice frees (then allocated per REQ-016) or its key releases (REQ-015); no steal logic synthesised.

Verification (NUM_KEYS=12, NUM_VOICES=4, DEBOUNCE_CYCLES=4)
REQ-026 Raw key 3 high for 3 cycles then low -> no gate, no trigger; high for 4 cycles held -> voice 0 gate=1, note=3, trigger one cycle at edge 6.
REQ-027 Keys 1,5,7 held together -> voices 0,1,2 allocated to notes 1,5,7 on three consecutive cycles, active_count_out=3.
REQ-028 Voices 0..3 hold notes 0,1,2,3 allocated in that order, then key 9 pressed -> with VOICE_STEAL_EN voice 0 note=9 gate stays 1 trigger pulses; without it, no change until key 2 releases, then voice 2 note=9 one cycle after gate drop.
REQ-029 Key 2 release and key 8 press flipping same cycle with all voices busy (voice 2 holds 2) -> voice 2 gate 0 first cycle, re-allocated to 8 next cycle (no-steal build).
REQ-030 Four voices active, rst_in pulsed mid-cycle -> all outputs 0 asynchronously; keys still held -> re-allocated from voice 0 after DEBOUNCE_CYCLES+2 edges post-reset.
